// File: rtl/crc32_pkg.sv
// CRC32 shared definitions for the frame checker and the 32-bit parallel generator.
// Polynomial 0x04C11DB7, MSB-first register. Data words are bit-reversed
// before entering the step. No final inversion is applied.
package crc32_pkg;

    localparam logic [31:0] CRC32_INIT = 32'hFFFF_FFFF;
    localparam logic [31:0] CRC32_POLY = 32'h04C1_1DB7;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        FRAME = 1'b1
    } chk_state_t;

    // Reverse the bit order of a 32-bit word.
    function automatic logic [31:0] bitrev32(input logic [31:0] d);
        logic [31:0] r;
        r = 32'h0000_0000;
        for (int i = 0; i < 32; i++) begin
            r[i] = d[31-i];
        end
        return r;
    endfunction

    // Advance the CRC register over 32 data bits, data[31] first.
    // The loop unrolls into the usual XOR network.
    function automatic logic [31:0] next_crc32_d32(input logic [31:0] data,
                                                   input logic [31:0] crc);
        logic [31:0] c;
        logic        fb;
        c = crc;
        for (int i = 31; i >= 0; i--) begin
            fb = c[31] ^ data[i];
            c  = {c[30:0], 1'b0} ^ (fb ? CRC32_POLY : 32'h0000_0000);
        end
        return c;
    endfunction

endpackage

// File: rtl/crc32_d32_step.sv
// Combinational single-word CRC32 step, shared by the generator and the checker.
import crc32_pkg::*;

module crc32_d32_step (
    input  logic [31:0] data,
    input  logic [31:0] crc,
    output logic [31:0] crc_next
);

    // Apply the 32-bit parallel CRC equations.
    always_comb begin
        crc_next = next_crc32_d32(data, crc);
    end

endmodule

// File: rtl/crc32_frame_checker.sv
// CRC32 receive-side frame checker.
// Takes frames whose eop word carries the CRC. It recomputes the CRC over the
// payload and strips the CRC word. Payload is forwarded through a one-word
// holding register (H) and a registered output stage. One result strobe is
// produced per frame.
// Optional build macro CRC_STATS_EN adds saturating good/bad/length-error counters.
import crc32_pkg::*;

module crc32_frame_checker #(
    parameter int MAX_WORDS = 1024,
    parameter int LEN_W     = 11
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [31:0]      s_data,
    input  logic             s_sop,
    input  logic             s_eop,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [31:0]      m_data,
    output logic             m_last,
    output logic             res_valid,
    output logic             res_crc_ok,
    output logic             res_len_err,
    output logic [LEN_W-1:0] res_len
`ifdef CRC_STATS_EN
    ,
    input  logic             stat_clr,
    output logic [31:0]      stat_good,
    output logic [31:0]      stat_bad,
    output logic [15:0]      stat_len_err
`endif
);

    localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_WORDS);
    localparam logic [LEN_W-1:0] LEN_SAT = LEN_W'(MAX_WORDS + 1);
    localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);

    chk_state_t        state_r;
    logic [31:0]       hold_r;
    logic              hold_valid_r;
    logic [31:0]       crc_r;
    logic [LEN_W-1:0]  len_r;

    logic              m_valid_r;
    logic [31:0]       m_data_r;
    logic              m_last_r;
    logic              res_valid_r;
    logic              res_crc_ok_r;
    logic              res_len_err_r;
    logic [LEN_W-1:0]  res_len_r;

    logic              accept_s;
    logic              fresh_s;
    logic [31:0]       crc_in_s;
    logic [31:0]       crc_step_s;
    logic [LEN_W-1:0]  len_inc_s;
    logic              crc_match_s;

    assign s_ready     = !m_valid_r || m_ready;
    assign accept_s    = s_valid && s_ready;

    assign m_valid     = m_valid_r;
    assign m_data      = m_data_r;
    assign m_last      = m_last_r;
    assign res_valid   = res_valid_r;
    assign res_crc_ok  = res_crc_ok_r;
    assign res_len_err = res_len_err_r;
    assign res_len     = res_len_r;

    // A sop word (in IDLE, or aborting a frame) restarts the CRC from INIT.
    always_comb begin
        fresh_s     = (state_r == IDLE) || s_sop;
        crc_in_s    = fresh_s ? CRC32_INIT : crc_r;
        len_inc_s   = (len_r >= LEN_SAT) ? LEN_SAT : (len_r + LEN_ONE);
        crc_match_s = (s_data == bitrev32(crc_r));
    end

    crc32_d32_step u_step (
        .data     (bitrev32(s_data)),
        .crc      (crc_in_s),
        .crc_next (crc_step_s)
    );

    // Frame FSM: holding register, output register, CRC/length tracking and result strobe.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r       <= IDLE;
            hold_r        <= 32'h0000_0000;
            hold_valid_r  <= 1'b0;
            crc_r         <= CRC32_INIT;
            len_r         <= '0;
            m_valid_r     <= 1'b0;
            m_data_r      <= 32'h0000_0000;
            m_last_r      <= 1'b0;
            res_valid_r   <= 1'b0;
            res_crc_ok_r  <= 1'b0;
            res_len_err_r <= 1'b0;
            res_len_r     <= '0;
        end else begin
            res_valid_r <= 1'b0;

            // Drain the output register. A forward below overrides this.
            if (m_valid_r && m_ready) begin
                m_valid_r <= 1'b0;
                m_last_r  <= 1'b0;
            end

            if (accept_s) begin
                case (state_r)
                    IDLE: begin
                        if (s_sop && !s_eop) begin
                            hold_r       <= s_data;
                            hold_valid_r <= 1'b1;
                            crc_r        <= crc_step_s;
                            len_r        <= LEN_ONE;
                            state_r      <= FRAME;
                        end else if (s_sop && s_eop) begin
                            // Zero-payload frame: nothing is forwarded.
                            res_valid_r   <= 1'b1;
                            res_crc_ok_r  <= 1'b0;
                            res_len_err_r <= 1'b1;
                            res_len_r     <= '0;
                        end else begin
                            // Any word outside a frame is discarded.
                            state_r <= IDLE;
                        end
                    end
                    FRAME: begin
                        if (s_sop) begin
                            // Abort: close the current frame and report it as a length error.
                            m_valid_r     <= hold_valid_r;
                            m_data_r      <= hold_r;
                            m_last_r      <= 1'b1;
                            res_valid_r   <= 1'b1;
                            res_crc_ok_r  <= 1'b0;
                            res_len_err_r <= 1'b1;
                            res_len_r     <= len_r;
                            if (!s_eop) begin
                                hold_r       <= s_data;
                                hold_valid_r <= 1'b1;
                                crc_r        <= crc_step_s;
                                len_r        <= LEN_ONE;
                            end else begin
                                // A sop+eop word cannot also get its own strobe this
                                // cycle, so it is dropped along with the aborted frame.
                                hold_valid_r <= 1'b0;
                                crc_r        <= CRC32_INIT;
                                len_r        <= '0;
                                state_r      <= IDLE;
                            end
                        end else if (s_eop) begin
                            m_valid_r     <= hold_valid_r;
                            m_data_r      <= hold_r;
                            m_last_r      <= 1'b1;
                            hold_valid_r  <= 1'b0;
                            res_valid_r   <= 1'b1;
                            res_crc_ok_r  <= crc_match_s;
                            res_len_err_r <= (len_r > LEN_MAX);
                            res_len_r     <= len_r;
                            crc_r         <= CRC32_INIT;
                            len_r         <= '0;
                            state_r       <= IDLE;
                        end else begin
                            m_valid_r <= hold_valid_r;
                            m_data_r  <= hold_r;
                            m_last_r  <= 1'b0;
                            hold_r    <= s_data;
                            crc_r     <= crc_step_s;
                            len_r     <= len_inc_s;
                        end
                    end
                    default: begin
                        state_r <= IDLE;
                    end
                endcase
            end
        end
    end

`ifdef CRC_STATS_EN
    logic [31:0] stat_good_r;
    logic [31:0] stat_bad_r;
    logic [15:0] stat_len_err_r;

    assign stat_good    = stat_good_r;
    assign stat_bad     = stat_bad_r;
    assign stat_len_err = stat_len_err_r;

    // Per-category saturating frame counters. A clear wins over a same-cycle increment.
    always_ff @(posedge clk) begin
        if (rst || stat_clr) begin
            stat_good_r    <= 32'h0000_0000;
            stat_bad_r     <= 32'h0000_0000;
            stat_len_err_r <= 16'h0000;
        end else if (res_valid_r) begin
            if (res_len_err_r) begin
                if (stat_len_err_r != 16'hFFFF) begin
                    stat_len_err_r <= stat_len_err_r + 16'h0001;
                end
            end else if (res_crc_ok_r) begin
                if (stat_good_r != 32'hFFFF_FFFF) begin
                    stat_good_r <= stat_good_r + 32'h0000_0001;
                end
            end else begin
                if (stat_bad_r != 32'hFFFF_FFFF) begin
                    stat_bad_r <= stat_bad_r + 32'h0000_0001;
                end
            end
        end
    end
`endif

endmodule
